// File: rtl/vga_timing_pkg.sv
// Shared timing constants and control-bundle types for the 640x480@60 Hz scan path.
package vga_timing_pkg;

  localparam int H_ACTIVE = 640;
  localparam int H_FP     = 16;
  localparam int H_SYNC   = 96;
  localparam int H_BP     = 48;
  localparam int H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;

  localparam int V_ACTIVE = 480;
  localparam int V_FP     = 10;
  localparam int V_SYNC   = 2;
  localparam int V_BP     = 33;
  localparam int V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam int H_SYNC_START = H_ACTIVE + H_FP;
  localparam int H_SYNC_END   = H_SYNC_START + H_SYNC - 1;
  localparam int V_SYNC_START = V_ACTIVE + V_FP;
  localparam int V_SYNC_END   = V_SYNC_START + V_SYNC - 1;

  localparam int PIPE_LAT     = 2;
  localparam int FRAME_PIXELS = 307200;

  localparam logic [3:0] MODE_PASS = 4'b0001;

  // Per-pixel control bits that travel alongside the ROM/core data path
  typedef struct packed {
    logic active;
    logic hs;
    logic vs;
  } scan_ctl_t;

endpackage

// File: rtl/vga_pipe_delay.sv
// Fixed-depth shift register with a loadable reset value, used to align control bits with pixel data.
module vga_pipe_delay #(
  parameter int DEPTH = 3,
  parameter int WIDTH = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] rst_val,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  logic [DEPTH-1:0][WIDTH-1:0] stage_r;

  // Shift one stage per clock; reset loads every stage with rst_val
  always_ff @(posedge clk) begin
    if (rst) begin
      stage_r <= {DEPTH{rst_val}};
    end else begin
      stage_r[0] <= din;
      for (int i = 1; i < DEPTH; i++) begin
        stage_r[i] <= stage_r[i-1];
      end
    end
  end

  assign dout = stage_r[DEPTH-1];

endmodule

// File: rtl/vga_scan_ctrl.sv
// Raster scan controller: pixel counters, row-major ROM addressing, frame-stable
// colour mode and sync/blank alignment with the ROM plus core latency.
module vga_scan_ctrl #(
  parameter int H_ACTIVE = vga_timing_pkg::H_ACTIVE,
  parameter int H_FP     = vga_timing_pkg::H_FP,
  parameter int H_SYNC   = vga_timing_pkg::H_SYNC,
  parameter int H_BP     = vga_timing_pkg::H_BP,
  parameter int V_ACTIVE = vga_timing_pkg::V_ACTIVE,
  parameter int V_FP     = vga_timing_pkg::V_FP,
  parameter int V_SYNC   = vga_timing_pkg::V_SYNC,
  parameter int V_BP     = vga_timing_pkg::V_BP,
  parameter int PIPE_LAT = vga_timing_pkg::PIPE_LAT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [3:0]  mode_req,
  input  logic [11:0] ripe_color,
  output logic [18:0] picture_addr,
  output logic [3:0]  state_info,
  output logic        frame_start,
  output logic        vga_hs,
  output logic        vga_vs,
  output logic [3:0]  vga_r,
  output logic [3:0]  vga_g,
  output logic [3:0]  vga_b
);

  import vga_timing_pkg::MODE_PASS;
  import vga_timing_pkg::scan_ctl_t;

  localparam int H_TOT    = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOT    = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int HS_FIRST = H_ACTIVE + H_FP;
  localparam int HS_LAST  = HS_FIRST + H_SYNC - 1;
  localparam int VS_FIRST = V_ACTIVE + V_FP;
  localparam int VS_LAST  = VS_FIRST + V_SYNC - 1;
  localparam int PIX_LAST = H_ACTIVE * V_ACTIVE - 1;
  localparam int HW       = $clog2(H_TOT);
  localparam int VW       = $clog2(V_TOT);
  localparam int DEPTH    = PIPE_LAT + 1;
  localparam scan_ctl_t CTL_IDLE = '{active: 1'b0, hs: 1'b1, vs: 1'b1};

  logic [HW-1:0] h_cnt_r;
  logic [VW-1:0] v_cnt_r;
  logic          origin_r;
  logic [18:0]   addr_r;
  logic [3:0]    state_r;
  logic [11:0]   rgb_r;
  logic          h_last_s;
  logic          v_last_s;
  logic          addr_last_s;
  logic          mode_load_s;
  scan_ctl_t     ctl0_s;
  scan_ctl_t     ctl_d_s;

  // Stage-0 decode of the current raster position
  always_comb begin
    h_last_s      = (h_cnt_r == HW'(H_TOT - 1));
    v_last_s      = (v_cnt_r == VW'(V_TOT - 1));
    addr_last_s   = (addr_r == 19'(PIX_LAST));
    mode_load_s   = (h_cnt_r == {HW{1'b0}}) && (v_cnt_r == VW'(V_ACTIVE));
    ctl0_s.active = (h_cnt_r < HW'(H_ACTIVE)) && (v_cnt_r < VW'(V_ACTIVE));
    ctl0_s.hs     = !((h_cnt_r >= HW'(HS_FIRST)) && (h_cnt_r <= HW'(HS_LAST)));
    ctl0_s.vs     = !((v_cnt_r >= VW'(VS_FIRST)) && (v_cnt_r <= VW'(VS_LAST)));
  end

  // Raster counters; origin_r flags the first pixel of every frame
  always_ff @(posedge clk) begin
    if (rst) begin
      h_cnt_r  <= {HW{1'b0}};
      v_cnt_r  <= {VW{1'b0}};
      origin_r <= 1'b1;
    end else begin
      origin_r <= h_last_s && v_last_s;
      if (h_last_s) begin
        h_cnt_r <= {HW{1'b0}};
        v_cnt_r <= v_last_s ? {VW{1'b0}} : v_cnt_r + VW'(1);
      end else begin
        h_cnt_r <= h_cnt_r + HW'(1);
        v_cnt_r <= v_cnt_r;
      end
    end
  end

  // Address advances only over active pixels and parks on the last one until the frame wraps
  always_ff @(posedge clk) begin
    if (rst) begin
      addr_r <= 19'd0;
    end else if (h_last_s && v_last_s) begin
      addr_r <= 19'd0;
    end else if (ctl0_s.active && !addr_last_s) begin
      addr_r <= addr_r + 19'd1;
    end else begin
      addr_r <= addr_r;
    end
  end

  // Colour mode is latched once per frame, after the last active line has drained
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= MODE_PASS;
    end else if (mode_load_s) begin
      state_r <= mode_req;
    end else begin
      state_r <= state_r;
    end
  end

  vga_pipe_delay #(
    .DEPTH(DEPTH),
    .WIDTH($bits(scan_ctl_t))
  ) u_ctl_delay (
    .clk    (clk),
    .rst    (rst),
    .rst_val(CTL_IDLE),
    .din    (ctl0_s),
    .dout   (ctl_d_s)
  );

  // Pixel capture lands in the same cycle as the delayed control bits, which then blank it
  always_ff @(posedge clk) begin
    if (rst) begin
      rgb_r <= 12'h000;
    end else begin
      rgb_r <= ripe_color;
    end
  end

  assign vga_r        = ctl_d_s.active ? rgb_r[11:8] : 4'd0;
  assign vga_g        = ctl_d_s.active ? rgb_r[7:4]  : 4'd0;
  assign vga_b        = ctl_d_s.active ? rgb_r[3:0]  : 4'd0;
  assign vga_hs       = ctl_d_s.hs;
  assign vga_vs       = ctl_d_s.vs;
  assign frame_start  = origin_r & ~rst;
  assign picture_addr = addr_r;
  assign state_info   = state_r;

endmodule

// File: tb/tb_vga_scan_ctrl.sv
// Bench for vga_scan_ctrl: spot-check table on the full 640x480 timing plus a
// per-cycle scoreboard on a reduced-size raster covering whole frames and resets.
module tb_vga_scan_ctrl;

  localparam int S_HA = 16, S_HFP = 2, S_HS = 3, S_HBP = 3;
  localparam int S_VA = 8,  S_VFP = 2, S_VS = 2, S_VBP = 3;
  localparam int S_HT = S_HA + S_HFP + S_HS + S_HBP;
  localparam int S_VT = S_VA + S_VFP + S_VS + S_VBP;
  localparam int S_FRAME = S_HT * S_VT;
  localparam int S_PIX = S_HA * S_VA;
  localparam int S_RST_N = 2 * S_FRAME + 5 * S_HT + 8;
  localparam int S_RUN = S_RST_N + 3 * S_FRAME + 10;
  localparam int B_RUN = 1610;
  localparam int NB = 20;

  typedef struct packed {
    logic        fs;
    logic [18:0] addr;
    logic        hs;
    logic        vs;
    logic [11:0] rgb;
    logic [3:0]  st;
  } obs_t;

  typedef struct {
    int   cyc;
    obs_t exp;
  } vec_t;

  logic        clk;
  logic        rst_b, rst_s;
  logic [3:0]  mode_b, mode_s;
  logic [11:0] ripe_b, ripe_s;
  logic [18:0] addr_b, addr_s;
  logic [3:0]  st_b, st_s;
  logic        fs_b, fs_s, hs_b, hs_s, vs_b, vs_s;
  logic [3:0]  r_b, g_b, b_b, r_s, g_s, b_s;

  logic [11:0] rb1, rb2, rs1, rs2;
  int          total, bad;
  obs_t        sb_q[$];
  vec_t        bt[NB];
  logic [3:0]  mode_tab[8] = '{4'b0010, 4'b0101, 4'b1001, 4'b0110,
                                4'b0000, 4'b0011, 4'b1111, 4'b0100};

  vga_scan_ctrl dut_b (
    .clk(clk), .rst(rst_b), .mode_req(mode_b), .ripe_color(ripe_b),
    .picture_addr(addr_b), .state_info(st_b), .frame_start(fs_b),
    .vga_hs(hs_b), .vga_vs(vs_b), .vga_r(r_b), .vga_g(g_b), .vga_b(b_b)
  );

  vga_scan_ctrl #(
    .H_ACTIVE(S_HA), .H_FP(S_HFP), .H_SYNC(S_HS), .H_BP(S_HBP),
    .V_ACTIVE(S_VA), .V_FP(S_VFP), .V_SYNC(S_VS), .V_BP(S_VBP), .PIPE_LAT(2)
  ) dut_s (
    .clk(clk), .rst(rst_s), .mode_req(mode_s), .ripe_color(ripe_s),
    .picture_addr(addr_s), .state_info(st_s), .frame_start(fs_s),
    .vga_hs(hs_s), .vga_vs(vs_s), .vga_r(r_s), .vga_g(g_s), .vga_b(b_s)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one clock; ROM (1 clk) + core (1 clk) modelled as a 2-deep history of picture_addr
  task automatic tick();
    @(posedge clk);
    #1;
    ripe_b = rb2; rb2 = rb1; rb1 = addr_b[11:0];
    ripe_s = rs2; rs2 = rs1; rs1 = addr_s[11:0];
  endtask

  function automatic obs_t obs_big();
    return {fs_b, addr_b, hs_b, vs_b, r_b, g_b, b_b, st_b};
  endfunction

  function automatic obs_t obs_small();
    return {fs_s, addr_s, hs_s, vs_s, r_s, g_s, b_s, st_s};
  endfunction

  task automatic check(string name, obs_t act, obs_t exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got fs=%0b addr=%0d hs=%0b vs=%0b rgb=%h st=%b, want fs=%0b addr=%0d hs=%0b vs=%0b rgb=%h st=%b",
               name, act.fs, act.addr, act.hs, act.vs, act.rgb, act.st,
               exp.fs, exp.addr, exp.hs, exp.vs, exp.rgb, exp.st);
    end
  endtask

  function automatic vec_t mk(int c, logic fs, int a, logic hs, logic [11:0] rgb);
    vec_t v;
    v.cyc = c;
    v.exp = '{fs, 19'(a), hs, 1'b1, rgb, 4'b0001};
    return v;
  endfunction

  // Reduced-raster reference, indexed by clocks since the last reset release
  function automatic int m_h(int k); return k % S_HT; endfunction
  function automatic int m_v(int k); return (k / S_HT) % S_VT; endfunction

  function automatic logic m_active(int k);
    if (k < 0) return 1'b0;
    return (m_h(k) < S_HA) && (m_v(k) < S_VA);
  endfunction

  function automatic logic m_hs(int k);
    if (k < 0) return 1'b1;
    return !((m_h(k) >= S_HA + S_HFP) && (m_h(k) < S_HA + S_HFP + S_HS));
  endfunction

  function automatic logic m_vs(int k);
    if (k < 0) return 1'b1;
    return !((m_v(k) >= S_VA + S_VFP) && (m_v(k) < S_VA + S_VFP + S_VS));
  endfunction

  function automatic int m_addr(int k);
    int h, v, nxt;
    h = m_h(k);
    v = m_v(k);
    if (h < S_HA && v < S_VA) return v * S_HA + h;
    if (v < S_VA) begin
      nxt = (v + 1) * S_HA;
      return (nxt > S_PIX - 1) ? S_PIX - 1 : nxt;
    end
    return S_PIX - 1;
  endfunction

  function automatic obs_t s_model(int k, logic [3:0] st, logic in_rst);
    obs_t o;
    o.fs   = (m_h(k) == 0) && (m_v(k) == 0) && !in_rst;
    o.addr = 19'(m_addr(k));
    o.hs   = m_hs(k - 3);
    o.vs   = m_vs(k - 3);
    o.rgb  = m_active(k - 3) ? 12'(m_addr(k - 3)) : 12'h000;
    o.st   = st;
    return o;
  endfunction

  initial begin
    int   ti, k;
    obs_t exp_o;
    logic [3:0] est;

    total = 0; bad = 0;
    rst_b = 1'b1; rst_s = 1'b1;
    mode_b = 4'b0011; mode_s = 4'b0000;
    ripe_b = 12'h000; ripe_s = 12'h000;
    rb1 = 12'h000; rb2 = 12'h000; rs1 = 12'h000; rs2 = 12'h000;

    // Full-size timing: cycle 0 is the first clock with rst low
    bt[0]  = mk(0,    1'b1, 0,    1'b1, 12'h000);
    bt[1]  = mk(1,    1'b0, 1,    1'b1, 12'h000);
    bt[2]  = mk(3,    1'b0, 3,    1'b1, 12'h000);
    bt[3]  = mk(4,    1'b0, 4,    1'b1, 12'h001);
    bt[4]  = mk(100,  1'b0, 100,  1'b1, 12'h061);
    bt[5]  = mk(639,  1'b0, 639,  1'b1, 12'h27C);
    bt[6]  = mk(640,  1'b0, 640,  1'b1, 12'h27D);
    bt[7]  = mk(642,  1'b0, 640,  1'b1, 12'h27F);
    bt[8]  = mk(643,  1'b0, 640,  1'b1, 12'h000);
    bt[9]  = mk(658,  1'b0, 640,  1'b1, 12'h000);
    bt[10] = mk(659,  1'b0, 640,  1'b0, 12'h000);
    bt[11] = mk(754,  1'b0, 640,  1'b0, 12'h000);
    bt[12] = mk(755,  1'b0, 640,  1'b1, 12'h000);
    bt[13] = mk(799,  1'b0, 640,  1'b1, 12'h000);
    bt[14] = mk(800,  1'b0, 640,  1'b1, 12'h000);
    bt[15] = mk(802,  1'b0, 642,  1'b1, 12'h000);
    bt[16] = mk(803,  1'b0, 643,  1'b1, 12'h280);
    bt[17] = mk(1459, 1'b0, 1280, 1'b0, 12'h000);
    bt[18] = mk(1600, 1'b0, 1280, 1'b1, 12'h000);
    bt[19] = mk(1603, 1'b0, 1283, 1'b1, 12'h500);

    repeat (3) tick();
    rst_b = 1'b0;
    ti = 0;
    for (int c = 0; c < B_RUN; c++) begin
      if (c > 0) tick();
      @(negedge clk);
      if (ti < NB && bt[ti].cyc == c) begin
        check($sformatf("big_c%0d", c), obs_big(), bt[ti].exp);
        ti++;
      end
    end
    total++;
    if (ti != NB) begin
      bad++;
      $display("FAIL big_table_reach: got %0d entries, want %0d", ti, NB);
    end

    // Reduced raster: held in reset so far
    tick();
    @(negedge clk);
    exp_o = '{1'b0, 19'd0, 1'b1, 1'b1, 12'h000, 4'b0001};
    check("small_in_reset", obs_small(), exp_o);

    tick();
    rst_s = 1'b0;
    k = 0;
    est = 4'b0001;
    for (int n = 0; n < S_RUN; n++) begin
      if (n > 0) tick();
      mode_s = mode_tab[(n / (S_HT * 3)) % 8];
      rst_s  = (n == S_RST_N);
      sb_q.push_back(s_model(k, est, rst_s));
      @(negedge clk);
      if (sb_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL scoreboard_empty: got 0 entries, want 1 at n=%0d", n);
      end else begin
        check($sformatf("scan_n%0d_k%0d", n, k), obs_small(), sb_q.pop_front());
      end
      if (rst_s) begin
        k = 0;
        est = 4'b0001;
      end else begin
        if (m_h(k) == 0 && m_v(k) == S_VA) est = mode_s;
        k++;
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
